// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load byte/halfword extraction (big-endian lanes),
// misaligned-load suppression, and a wrapping retired-instruction counter.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_wreg,
  input  logic [4:0]       mem_wd,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_ld,
  input  logic [2:0]       mem_ldop,
  input  logic [31:0]      mem_rdata,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  // Reserved load types fall through to the full-word path.
  function automatic logic [31:0] f_load_data(input logic [2:0]  i_op,
                                              input logic [1:0]  i_a,
                                              input logic [31:0] i_rd);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    case (i_a)
      2'd0:    w_byte = i_rd[31:24];
      2'd1:    w_byte = i_rd[23:16];
      2'd2:    w_byte = i_rd[15:8];
      2'd3:    w_byte = i_rd[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = i_a[1] ? i_rd[15:0] : i_rd[31:16];
    case (i_op)
      LD_LB:   f_load_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  f_load_data = {24'h000000, w_byte};
      LD_LH:   f_load_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  f_load_data = {16'h0000, w_half};
      default: f_load_data = i_rd;
    endcase
  endfunction

  logic             w_is_half;
  logic             w_is_word;
  logic             w_misalign;
  logic             w_nx_we;
  logic [4:0]       w_nx_waddr;
  logic [31:0]      w_nx_wdata;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;
  logic             r_misalign;
  logic [CNT_W-1:0] r_retire_cnt;

  // Next-state values for a capture edge.
  always_comb begin
    w_is_half  = (mem_ldop == LD_LH) || (mem_ldop == LD_LHU);
    w_is_word  = (mem_ldop != LD_LB) && (mem_ldop != LD_LBU) && !w_is_half;
    w_misalign = mem_valid & mem_ld &
                 ((w_is_word & (mem_wdata[1:0] != 2'b00)) | (w_is_half & mem_wdata[0]));
    w_nx_we    = mem_valid & mem_wreg & (mem_wd != 5'd0) & ~w_misalign;
    if (mem_valid) begin
      w_nx_waddr = mem_wd;
    end else begin
      w_nx_waddr = 5'd0;
    end
    if (!mem_valid || w_misalign) begin
      w_nx_wdata = 32'h0000_0000;
    end else if (mem_ld) begin
      w_nx_wdata = f_load_data(mem_ldop, mem_wdata[1:0], mem_rdata);
    end else begin
      w_nx_wdata = mem_wdata;
    end
  end

  // Stage register: reset > flush > stall > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_waddr      <= 5'd0;
      r_wdata      <= 32'h0000_0000;
      r_misalign   <= 1'b0;
      r_retire_cnt <= '0;
    end else if (flush) begin
      r_we       <= 1'b0;
      r_waddr    <= 5'd0;
      r_wdata    <= 32'h0000_0000;
      r_misalign <= 1'b0;
    end else if (!stall) begin
      r_we       <= w_nx_we;
      r_waddr    <= w_nx_waddr;
      r_wdata    <= w_nx_wdata;
      r_misalign <= w_misalign;
      if (mem_valid) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign wb_we       = r_we;
  assign wb_waddr    = r_waddr;
  assign wb_wdata    = r_wdata;
  assign wb_misalign = r_misalign;
  assign retire_cnt  = r_retire_cnt;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the retire counter.
REQ-002 SHALL use one clock; reset is asynchronous and active-high. Ports: clk, rst.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port stall  input  1  holds the stage register.
REQ-006 SHALL have port flush  input  1  inserts a bubble.
REQ-007 SHALL have port mem_valid  input  1  MEM stage holds a real instruction.
REQ-008 SHALL have port mem_wreg  input  1  instruction writes a GPR.
REQ-009 SHALL have port mem_wd  input  5  destination GPR address.
REQ-010 SHALL have port mem_wdata  input  32  ALU result, or byte address for loads.
REQ-011 SHALL have port mem_ld  input  1  instruction is a load.
REQ-012 SHALL have port mem_ldop  input  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others reserved.
REQ-013 SHALL have port mem_rdata  input  32  data-memory word read at {mem_wdata[31:2],2'b00}.
REQ-014 SHALL have port wb_we  output  1  regfile write enable.
REQ-015 SHALL have port wb_waddr  output  5  regfile write address.
REQ-016 SHALL have port wb_wdata  output  32  regfile write data.
REQ-017 SHALL have port wb_misalign  output  1  registered misaligned-load flag.
REQ-018 SHALL have port retire_cnt  output  CNT_W  count of retired instructions.

Function
REQ-019 SHALL register every output, giving a 1-cycle latency from MEM inputs to WB outputs.
REQ-020 SHALL apply per-edge priority rst > flush > stall > capture.
REQ-021 SHALL, on flush, load the bubble values wb_we=0, wb_waddr=0, wb_wdata=0 and wb_misalign=0, and leave retire_cnt unchanged.
REQ-022 SHALL, on stall without flush, hold all outputs including retire_cnt.
REQ-023 SHALL, on capture, set wb_we = mem_valid & mem_wreg & (mem_wd!=0) & ~misalign.
REQ-024 SHALL, on capture, set wb_waddr = mem_wd.
REQ-025 SHALL, on capture with mem_ld=0, set wb_wdata = mem_wdata.
REQ-026 SHALL use big-endian byte lanes for loads: a=mem_wdata[1:0]; a=0 selects rdata[31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
REQ-027 SHALL handle lb/lbu as follows: the selected byte is sign-extended (lb) or zero-extended (lbu).
REQ-028 SHALL handle lh/lhu as follows: a[1]=0 selects rdata[31:16] and a[1]=1 selects [15:0]; the halfword is sign-extended (lh) or zero-extended (lhu).
REQ-029 SHALL flag misalign = mem_valid & mem_ld & ((lw & a!=0) | ((lh|lhu) & a[0])), and register the flag as wb_misalign.
REQ-030 SHALL, on a misaligned load, force wb_we=0 and wb_wdata=0.
REQ-031 SHALL treat a reserved mem_ldop with mem_ld=1 as lw.
REQ-032 SHALL increment retire_cnt by 1 on a capture edge when mem_valid=1, including misaligned loads and writes to $0.
REQ-033 SHALL wrap retire_cnt modulo 2^CNT_W (all-ones -> 0) with no sticky flag.
REQ-034 SHALL ignore mem_* inputs when mem_valid=0 and produce the bubble values on capture.

Reset
REQ-035 SHALL, while rst=1, asynchronously force wb_we=0, wb_waddr=0, wb_wdata=0, wb_misalign=0 and retire_cnt=0, independent of clk.
REQ-036 SHALL, on rst asserted mid-stall or mid-flush, discard the held contents; the first capture edge after deassertion loads fresh inputs.

Verification
REQ-037 SHALL verify: valid ALU op with wd=5, wdata=0x1234_5678 -> next edge: wb_we=1, waddr=5, wdata=0x1234_5678, retire_cnt=1.
REQ-038 SHALL verify: rdata=0x80FF_7F01 with lb at a=0..3 -> 0xFFFF_FF80, 0xFFFF_FFFF, 0x0000_007F, 0x0000_0001; with lhu at a=2 -> 0x0000_7F01; with lh at a=0 -> 0xFFFF_80FF.
REQ-039 SHALL verify: lw with address 0x...2 -> wb_misalign=1, wb_we=0, wb_wdata=0, and retire_cnt increments.
REQ-040 SHALL verify: stall=1 for 3 cycles while inputs change -> outputs and retire_cnt are frozen; stall=1 with flush=1 -> bubble is loaded.
REQ-041 SHALL verify: retire_cnt preloaded to 0xFFFF_FFFF by 2^32-1 retirements (or CNT_W=4 with 15 retirements) -> one further valid capture gives 0.
REQ-042 SHALL verify: rst pulse between clock edges during a valid stream -> outputs read 0 immediately, before any clock edge.
